uart_rx_fifo: RTL
=================

# uart_rx_fifo

Synthesizable UART receiver with a buffered byte output. It sits directly downstream of the testbench UART model's `tx` line, in the SoC peripheral path. It oversamples the serial line at the system clock and frames 8N1 characters, with optional even parity. It pushes good bytes into a first-word-fall-through FIFO that the consumer drains with a valid/ready handshake.

## Interface
- `FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115_200, line rate in baud; `CPS = FREQ/BAUD` (integer divide), CPS must be ≥ 4 and < 2^16
- `DEPTH`, 8, FIFO entries, power of two, ≥ 2

- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `rx_data`  out  8  FIFO head byte, valid while `rx_valid`
- `rx_valid`  out  1  FIFO not empty
- `rx_ready`  in  1  consumer accepts head when `rx_valid && rx_ready`
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `parity_err`  out  1  one-cycle pulse: parity mismatch (0 when parity compiled out)
- `overrun`  out  1  one-cycle pulse: byte dropped because FIFO full

## Operation
- Two-flop synchronizer on `rx`; both flops reset to 1. All FSM decisions use the synchronized value `rxs`.
- 16-bit bit-timer `cnt`, cleared on every state entry. A "tick" fires when `cnt == CPS-1`; a "half" fires when `cnt == CPS/2-1`.
- FSM states:
  - IDLE: on `rxs == 0` → START.
  - START: at half, if `rxs == 1` → IDLE (glitch, nothing reported); otherwise → DATA with `bit = 0`.
  - DATA: at each tick, `shift[bit] <= rxs`, LSB first. After bit 7 → PARITY if enabled, else STOP.
  - PARITY: at tick, record `perr = rxs ^ (^shift)` (even parity) → STOP.
  - STOP: at tick:
    - `rxs == 0` → `frame_err` pulse, byte discarded → BREAK.
    - `perr` → `parity_err` pulse, byte discarded → IDLE.
    - Otherwise push; if FIFO full and no pop this cycle → `overrun` pulse, new byte dropped → IDLE.
  - BREAK: wait for `rxs == 1` → IDLE. Prevents a held-low line from generating repeated frames.
- A frame error takes priority over a parity error; at most one error pulse per frame.
- FIFO: DEPTH×8 array, read/write pointers of $clog2(DEPTH)+1 bits that wrap naturally. Full = pointers differ only in the MSB. `rx_data` = `mem[rd_ptr]`, combinational from registered state.
- Push and pop in the same cycle:
  - Both succeed and `level` is unchanged.
  - When full, the pop frees the slot, so the push is accepted and there is no overrun.
- A pop while empty is ignored.

## Timing
- Reset values:
  - `rx_valid=0`, `level=0`, `frame_err=0`, `parity_err=0`, `overrun=0`
  - `rx_data=0` (memory cleared on reset)
  - FSM in IDLE, synchronizer at 1, pointers 0
- Reset asserted mid-frame or mid-drain aborts immediately; the partial frame is lost and the FIFO is emptied.
- Latency, measured from the first `clk` edge that samples `rx` low:
  - 2 cycles through the synchronizer plus 1 cycle for IDLE→START.
  - The push lands at the STOP tick; `rx_valid`/`level` update on the following edge.
  - Without parity: 3 + CPS/2 + 9·CPS cycles. With parity: add CPS.
- Error pulses are registered and assert on the cycle after the STOP tick, for exactly one cycle.
- The receiver returns to IDLE mid-stop-bit, so back-to-back frames with a one-bit stop are received without loss.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - 11-bit frames (start, 8 data, even parity, stop); PARITY state present.
  - `parity_err` is live.
- Not defined:
  - 10-bit 8N1 frames; PARITY state and parity logic are absent.
  - `parity_err` is tied to 0.

## Test plan
Unless stated otherwise: FREQ=1_000_000, BAUD=100_000 (CPS=10), DEPTH=4.

1. **Single byte:** drive 0xA5 at 8N1 → `rx_valid` rises exactly 98 cycles after the start edge; `rx_data=0xA5`; `level=1`; no error pulses; pop with `rx_ready=1` → `rx_valid=0`.
2. **Overrun:** `rx_ready=0`, send 0x01..0x05 back-to-back → `level` saturates at 4; exactly one `overrun` pulse, on byte 0x05; draining yields 0x01..0x04 in order.
3. **Full with simultaneous pop:** FIFO full, assert `rx_ready` on the 5th byte's push cycle → no `overrun`; `level` stays 4; last entry is the 5th byte.
4. **Framing/break:** send 0x3C with the stop bit low, then hold `rx` low for 50 bit times, then release → one `frame_err` pulse; nothing pushed; the next valid byte 0x7E is received correctly.
5. **Glitch and reset:**
   - 3-cycle low pulse on idle `rx` → nothing pushed, no errors.
   - Assert `rst_n=0` mid-data-bit with `level=2` → all outputs return to reset values asynchronously.
6. **Parity (`UART_RX_PARITY_EN`):** send 0x07 with parity 1 → accepted. Send 0x07 with parity 0 → one `parity_err` pulse, byte not pushed.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Consumer-side handshake bundle for uart_rx_fifo.
//   rx_data  : FIFO head byte, valid while rx_valid
//   rx_valid : FIFO not empty
//   rx_ready : consumer accepts the head when rx_valid && rx_ready
//   level    : current FIFO occupancy
// Modports:
//   master : the receiver/FIFO side (drives data, valid, level)
//   slave  : the consumer side (drives ready)
interface uart_rx_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [LW-1:0] level;

    modport master (
        output rx_data,
        output rx_valid,
        output level,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  level,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// UART receiver (8 data bits, LSB first, one stop bit) oversampled at the
// system clock, feeding a first-word-fall-through byte FIFO.
//
// Optional feature: define UART_RX_PARITY_EN to receive an even parity bit
// between the data and stop bits; without it parity_err is tied to 0.
//
// Parameters:
//   FREQ  : system clock in Hz
//   BAUD  : line rate; CPS = FREQ/BAUD clocks per bit (4 <= CPS < 2^16)
//   DEPTH : FIFO entries, power of two, >= 2
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : serial line, idle high, asynchronous to clk
//   bus        : consumer handshake (rx_data, rx_valid, rx_ready, level)
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch
//   overrun    : one-cycle pulse, byte dropped because FIFO full
module uart_rx_fifo #(
    parameter int FREQ  = 50_000_000,
    parameter int BAUD  = 115_200,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    uart_rx_fifo_if.master    bus,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);
    localparam int CPS = FREQ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;

    localparam logic [15:0] TICK_CNT = 16'(CPS - 1);
    localparam logic [15:0] HALF_CNT = 16'(CPS / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    // ------------------------------------------------------------------
    // Two-flop synchronizer, reset to the idle (high) line level
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bitn;
    logic [7:0]  shift;
    logic        push_q;
    logic [7:0]  push_byte;
    logic        tick;
    logic        half;

    assign tick = (cnt == TICK_CNT);
    assign half = (cnt == HALF_CNT);

`ifdef UART_RX_PARITY_EN
    logic perr;
    logic perr_pulse;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bitn      <= '0;
            shift     <= '0;
            push_q    <= 1'b0;
            push_byte <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr       <= 1'b0;
            perr_pulse <= 1'b0;
`endif
        end else begin
            push_q    <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_pulse <= 1'b0;
`endif
            cnt <= cnt + 16'd1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (half) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                            bitn  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt         <= '0;
                        shift[bitn] <= rxs;
                        bitn        <= bitn + 3'd1;
                        if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        cnt   <= '0;
                        perr  <= rxs ^ (^shift);
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Decision at mid stop bit so back-to-back frames fit.
                    if (tick) begin
                        cnt <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
`ifdef UART_RX_PARITY_EN
                        end else if (perr) begin
                            perr_pulse <= 1'b1;
                            state      <= S_IDLE;
`endif
                        end else begin
                            push_q    <= 1'b1;
                            push_byte <= shift;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_BREAK: begin
                    cnt <= '0;
                    if (rxs) state <= S_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_pulse;
`else
    assign parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FWFT FIFO; pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign pop     = !empty && bus.rx_ready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    assign push_ok = push_q && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_q && full && !pop;
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_byte;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign bus.rx_data  = mem[rd_ptr[AW-1:0]];
    assign bus.rx_valid = !empty;
    assign bus.level    = wr_ptr - rd_ptr;

endmodule
